// File: rtl/step_decoder_pkg.sv
// Shared types and constants for the step decoder: FSM states, step classes, re-lock threshold.
package step_decoder_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    BAD  = 2'd3
  } step_t;

  localparam int RELOCK_CNT = 2;

  // Wrapping 3-bit difference; 7->0 yields 1 and 0->7 yields 7 for free.
  function automatic logic [2:0] step_delta(input logic [2:0] prev, input logic [2:0] q);
    return q - prev;
  endfunction

endpackage

// File: rtl/step_decoder_if.sv
// Counter-observation bundle: sampled count and clear in, step/position/status out.
interface step_decoder_if #(
  parameter int POS_W = 8
);
  logic [2:0]       q;
  logic             clr;
  logic             en;
  logic             down;
  logic [POS_W-1:0] pos;
  logic             locked;
  logic             err;
`ifdef STEP_DECODER_ERRCNT_EN
  logic [3:0]       err_cnt;

  modport master (output q, clr, input en, down, pos, locked, err, err_cnt);
  modport slave  (input q, clr, output en, down, pos, locked, err, err_cnt);
`else
  modport master (output q, clr, input en, down, pos, locked, err);
  modport slave  (input q, clr, output en, down, pos, locked, err);
`endif
endinterface

// File: rtl/step_decoder_step_cls.sv
// Combinational classifier of one counter sample against the previous one.
module step_cls
  import step_decoder_pkg::*;
(
  input  logic [2:0] prev,
  input  logic [2:0] q,
  output step_t      cls
);

  logic [2:0] delta;

  assign delta = step_delta(prev, q);

  always_comb begin
    cls = BAD;
    case (delta)
      3'd0:    cls = HOLD;
      3'd1:    cls = UP;
      3'd7:    cls = DN;
      default: cls = BAD;
    endcase
  end

endmodule

// File: rtl/step_decoder.sv
// Decodes single steps of an observed 3-bit counter into en/down pulses and a signed position; one cycle q->outputs.
// No backpressure: q is sampled every cycle. Optional STEP_DECODER_ERRCNT_EN adds a saturating fault counter.
module step_decoder
  import step_decoder_pkg::*;
#(
  parameter int POS_W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  step_decoder_if.slave bus
);

  state_t           state, state_nxt;
  logic [2:0]       prev;
  logic [1:0]       quiet, quiet_nxt;
  step_t            cls;
  logic             step_up, step_dn, fault_entry;

  logic             en_r, down_r, locked_r, err_r;
  logic [POS_W-1:0] pos_r;

  step_cls u_step_cls (
    .prev (prev),
    .q    (bus.q),
    .cls  (cls)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ACQ;
      prev  <= 3'd0;
      quiet <= 2'd0;
    end else begin
      state <= state_nxt;
      prev  <= bus.q;
      quiet <= quiet_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    quiet_nxt   = quiet;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    fault_entry = 1'b0;
    case (state)
      ACQ: begin
        state_nxt = LOCKED;
        quiet_nxt = 2'd0;
      end
      LOCKED: begin
        case (cls)
          UP: step_up = 1'b1;
          DN: step_dn = 1'b1;
          BAD: begin
            state_nxt   = FAULT;
            quiet_nxt   = 2'd0;
            fault_entry = 1'b1;
          end
          default: ;
        endcase
      end
      FAULT: begin
        // Any movement, even a legal single step, restarts the quiet run.
        if (cls == HOLD) begin
          if (quiet == 2'(RELOCK_CNT - 1)) begin
            state_nxt = LOCKED;
            quiet_nxt = 2'd0;
          end else begin
            quiet_nxt = quiet + 2'd1;
          end
        end else begin
          quiet_nxt = 2'd0;
        end
      end
      default: begin
        state_nxt = ACQ;
        quiet_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_r     <= 1'b0;
      down_r   <= 1'b0;
      pos_r    <= '0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      en_r     <= step_up | step_dn;
      locked_r <= (state_nxt == LOCKED);
      err_r    <= fault_entry;
      if (step_dn)
        down_r <= 1'b1;
      else if (step_up)
        down_r <= 1'b0;
      // clr wins over a coincident step; en/down still report the step.
      if (bus.clr)
        pos_r <= '0;
      else if (step_up)
        pos_r <= pos_r + POS_W'(1);
      else if (step_dn)
        pos_r <= pos_r - POS_W'(1);
    end
  end

  assign bus.en     = en_r;
  assign bus.down   = down_r;
  assign bus.pos    = pos_r;
  assign bus.locked = locked_r;
  assign bus.err    = err_r;

`ifdef STEP_DECODER_ERRCNT_EN
  logic [3:0] err_cnt_r;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      err_cnt_r <= 4'd0;
    else if (bus.clr)
      err_cnt_r <= 4'd0;
    else if (fault_entry && err_cnt_r != 4'd15)
      err_cnt_r <= err_cnt_r + 4'd1;
  end

  assign bus.err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_step_decoder.sv
// Randomized and directed bench for step_decoder against a behavioural model of the step rules.
module tb_step_decoder;
  import step_decoder_pkg::*;

  localparam int POS_W = 8;
  localparam int MASK  = (1 << POS_W) - 1;

  logic clk;
  logic nrst;

  step_decoder_if #(.POS_W(POS_W)) bus ();

  step_decoder #(.POS_W(POS_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: 0 = acquiring, 1 = locked, 2 = faulted
  int m_mode, m_prev, m_quiet, m_pos, m_errcnt;
  int m_en, m_down, m_err, m_locked;
  int cur_q;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_quiet = 0; m_pos = 0; m_errcnt = 0;
    m_en = 0; m_down = 0; m_err = 0; m_locked = 0;
  endtask

  task automatic model_edge(input int qv, input int c);
    int d;
    d = (qv - m_prev + 8) % 8;
    m_en = 0;
    m_err = 0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (d == 1) begin
        m_en = 1; m_down = 0; m_pos = m_pos + 1;
      end else if (d == 7) begin
        m_en = 1; m_down = 1; m_pos = m_pos - 1;
      end else if (d != 0) begin
        m_mode = 2; m_err = 1; m_quiet = 0;
        if (m_errcnt < 15) m_errcnt++;
      end
    end else begin
      if (d == 0) begin
        m_quiet++;
        if (m_quiet >= RELOCK_CNT) begin
          m_mode = 1; m_quiet = 0;
        end
      end else begin
        m_quiet = 0;
      end
    end
    if (c != 0) begin
      m_pos = 0;
      m_errcnt = 0;
    end
    m_pos    = m_pos & MASK;
    m_prev   = qv;
    m_locked = (m_mode == 1);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".en"},     bus.en,     m_en);
    check({tag, ".down"},   bus.down,   m_down);
    check({tag, ".pos"},    bus.pos,    m_pos);
    check({tag, ".locked"}, bus.locked, m_locked);
    check({tag, ".err"},    bus.err,    m_err);
`ifdef STEP_DECODER_ERRCNT_EN
    check({tag, ".err_cnt"}, bus.err_cnt, m_errcnt);
`endif
  endtask

  task automatic drive(input int qv, input int c, input string tag);
    bus.q   = qv[2:0];
    bus.clr = c[0];
    cur_q   = qv & 7;
    @(posedge clk);
    #1;
    if (nrst == 1'b0) model_reset();
    else model_edge(qv & 7, c);
    check_all(tag);
  endtask

  initial begin
    int en_cnt;
    int r, dq;

    model_reset();
    nrst    = 1'b0;
    bus.q   = 3'd3;
    bus.clr = 1'b0;
    cur_q   = 3;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Lock on a static count; no steps may be reported.
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(3, 0, "hold3");
      if (i == 0) check("hold3.locked_first", bus.locked, 1);
      en_cnt += bus.en;
    end
    check("hold3.en_total", en_cnt, 0);
    check("hold3.pos", bus.pos, 0);

    // Up through the 7->0 wrap.
    en_cnt = 0;
    for (int v = 4; v <= 8; v++) begin
      drive(v & 7, 0, "up");
      en_cnt += bus.en;
    end
    check("up.en_total", en_cnt, 5);
    check("up.pos", bus.pos, 5);
    check("up.down", bus.down, 0);

    // Down through the 0->7 wrap from pos 0.
    drive(0, 1, "clr0");
    drive(7, 0, "dn7");
    check("dn7.down", bus.down, 1);
    drive(6, 0, "dn6");
    check("dn6.pos", bus.pos, 8'hFE);

    // Illegal jump 2->5, then re-lock after two quiet samples.
    for (int v = 5; v >= 2; v--) drive(v, 0, "walk");
    r = bus.pos;
    drive(5, 0, "jump");
    check("jump.err", bus.err, 1);
    check("jump.locked", bus.locked, 0);
    check("jump.pos", bus.pos, r);
    drive(5, 0, "quiet1");
    check("quiet1.locked", bus.locked, 0);
    check("quiet1.err", bus.err, 0);
    drive(5, 0, "quiet2");
    check("quiet2.locked", bus.locked, 1);
`ifdef STEP_DECODER_ERRCNT_EN
    check("quiet2.err_cnt", bus.err_cnt, 1);
`endif

    // Clear coinciding with a step at pos 9.
    drive(4, 0, "pre");
    drive(3, 1, "clr3");
    for (int i = 1; i <= 9; i++) drive((3 + i) & 7, 0, "to9");
    check("to9.pos", bus.pos, 9);
    drive(5, 1, "clrstep");
    check("clrstep.pos", bus.pos, 0);
    check("clrstep.en", bus.en, 1);
    check("clrstep.down", bus.down, 0);

    // Asynchronous reset between edges at pos 0x40.
    for (int i = 0; i < 64; i++) drive((cur_q + 1) & 7, 0, "to40");
    check("to40.pos", bus.pos, 8'h40);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    drive(cur_q, 0, "arst_hold");
    nrst = 1'b1;
    drive(cur_q, 0, "acq");
    check("acq.en", bus.en, 0);
    check("acq.locked", bus.locked, 1);

    // Random walk: mostly legal steps, occasional jumps and clears.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) dq = 0;
      else if (r < 6) dq = 1;
      else if (r < 9) dq = 7;
      else dq = $urandom_range(2, 6);
      drive((cur_q + dq) & 7, ($urandom_range(0, 15) == 0) ? 1 : 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/step_decoder.md
STEP_DECODER -- requirements
Module: step_decoder

Interface
REQ-001 Parameter: POS_W, default 8, width of the position accumulator (legal range 4..16).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: nrst  input  1  asynchronous, active-low reset.
REQ-004 Port: q  input  3  observed value of a 3-bit up/down counter, sampled every clk.
REQ-005 Port: clr  input  1  synchronous clear of pos, active-high.
REQ-006 Port: en  output  1  registered, one-cycle pulse per detected single step.
REQ-007 Port: down  output  1  registered direction of the last detected step, 1 = decrement.
REQ-008 Port: pos  output  POS_W  registered signed step accumulator, two's complement.
REQ-009 Port: locked  output  1  registered, 1 while state is LOCKED.
REQ-010 Port: err  output  1  registered, one-cycle pulse on entry to FAULT.

Function
REQ-011 The block SHALL hold a 3-bit register prev of the last sampled q, and compute delta = (q - prev) mod 8.
REQ-012 The FSM SHALL have states ACQ, LOCKED, FAULT.
REQ-013 ACQ: SHALL load prev <= q and go to LOCKED on the next edge; no en, no pos change.
REQ-014 LOCKED, delta 0: SHALL stay; en = 0; down and pos hold.
REQ-015 LOCKED, delta 1: SHALL assert en = 1, down = 0, pos <= pos + 1 on the same edge.
REQ-016 LOCKED, delta 7: SHALL assert en = 1, down = 1, pos <= pos - 1 on the same edge.
REQ-017 LOCKED, delta 2..6: SHALL go to FAULT, pulse err for one cycle, leave en = 0 and pos unchanged.
REQ-018 FAULT: SHALL re-lock to LOCKED after q is equal to prev for 2 consecutive samples; any change restarts the count.
REQ-019 prev SHALL update with q every cycle in every state.
REQ-020 Latency: en/down/pos/err SHALL reflect the q sampled at edge N by the output value after edge N, one cycle from q to outputs.
REQ-021 pos SHALL wrap modulo 2^POS_W (0x7F + 1 = 0x80 for POS_W = 8), with no saturation.
REQ-022 q wrap 7->0 SHALL be an up step, and 0->7 SHALL be a down step.
REQ-023 clr SHALL set pos to 0 and take priority over a simultaneous step; en/down SHALL still report that step.
REQ-024 clr SHALL NOT affect the FSM, prev, or locked.

Reset
REQ-025 nrst low SHALL immediately force: state ACQ, prev = 0, en = 0, down = 0, pos = 0, locked = 0, err = 0, fault counters = 0.
REQ-026 Reset asserted mid-step SHALL discard any pending step; after release the first edge behaves as ACQ.

Configuration
REQ-027 Macro STEP_DECODER_ERRCNT_EN, when defined, SHALL add output err_cnt[3:0], which increments on each FAULT entry, saturates at 15, is reset to 0 by nrst and clr.
REQ-028 Without STEP_DECODER_ERRCNT_EN, err_cnt SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-029 Package step_decoder_pkg SHALL hold the state enum (ACQ, LOCKED, FAULT), the step-class enum (HOLD, UP, DN, BAD), and the constant RELOCK_CNT = 2.
REQ-030 A combinational sub-module step_cls SHALL map (prev, q) to the step class, and be instantiated once.

Verification
REQ-031 Reset release, q held 3 for 4 cycles -> locked = 1 after 1st edge, en never 1, pos = 0.
REQ-032 q 3,4,5,6,7,0 after lock -> five en pulses, down = 0, pos = 5, 7->0 counted up.
REQ-033 q 0,7,6 from pos = 0 (POS_W = 8) -> two en with down = 1, pos = 0xFE.
REQ-034 q 2->5 while locked -> err pulse, locked = 0, pos unchanged; q held 5 two cycles -> locked = 1; with the macro, err_cnt = 1.
REQ-035 clr = 1 on the same edge as step 4->5 with pos = 9 -> pos = 0, en = 1, down = 0.
REQ-036 nrst asserted between clock edges with pos = 0x40 -> all outputs 0 without waiting for a clock edge; next edge is ACQ.
